dac_frame_rx: RTL and testbench

Receive-side counterpart of the DAC SPI write path. It deserializes 24-bit DAC frames (sync/sclk/sdi) in the wb_clk_i domain and validates the command and tail fields. It presents the decoded 16-bit threshold code as a strobed output and exposes status, the last code and the raw frame through a Wishbone slave. It is used as a loopback checker on the DAC lines and as the DAC model in system benches.

---
 rtl/dac_rx_pkg.sv | 30 +++
 rtl/dac_frame_rx_sig_sync.sv | 34 +++
 rtl/dac_frame_rx.sv | 170 +++++++++++++++++
 tb/tb_dac_frame_rx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_rx_pkg.sv
// dac_rx_pkg: shared types and constants for the DAC frame receiver.
//   - rx_state_e   : frame FSM states (ARM, IDLE, SHIFT, CHECK)
//   - *_REG        : Wishbone register indices (byte address bits [3:2])
//   - STAT_*       : STATUS register bit positions
//   - DEF_*        : default frame geometry and command value
package dac_rx_pkg;

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_CHECK = 2'd3
    } rx_state_e;

    localparam logic [1:0] STATUS_REG = 2'd0;
    localparam logic [1:0] CODE_REG   = 2'd1;
    localparam logic [1:0] RAW_REG    = 2'd2;

    localparam int STAT_VLD_BIT     = 0;
    localparam int STAT_LEN_BIT     = 1;
    localparam int STAT_CMD_BIT     = 2;
    localparam int STAT_CLR_CNT_BIT = 3;   // write-only: clears frame_cnt
    localparam int STAT_CNT_LSB     = 16;

    localparam int         DEF_FRAME_WIDTH  = 24;
    localparam int         DEF_CODE_WIDTH   = 16;
    localparam int         DEF_SYNC_STAGES  = 2;
    localparam logic [3:0] DEF_EXPECTED_CMD = 4'b0011;

endpackage

// File: rtl/dac_frame_rx_sig_sync.sv
// sig_sync: STAGES-deep synchronizer with single-cycle edge pulses.
//   wb_clk_i, wb_rst_i : clock, async active-high reset
//   din                : asynchronous input
//   q                  : synchronized level
//   rise / fall        : one-cycle pulses on q transitions
module sig_sync #(
    parameter int STAGES = 2
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              q_d;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            chain <= '0;
            q_d   <= 1'b0;
        end else begin
            chain <= (chain << 1) | STAGES'(din);
            q_d   <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/dac_frame_rx.sv
// dac_frame_rx: deserializes 24-bit DAC SPI frames (sync/sclk/sdi) in the
// wb_clk_i domain, validates length and (optionally) command/tail fields,
// strobes the decoded code, and exposes status/code/raw frame over Wishbone.
//   wb_*        : Wishbone slave (regs: 0 STATUS, 1 CODE, 2 RAW)
//   sync_i      : frame select, active-low
//   sclk_i      : serial clock, sdi sampled on falling edge, MSB first
//   sdi_i       : serial data
//   code_o      : last accepted code, code_vld_o pulses when it updates
//   frame_err_o : pulses on a rejected frame
// Build option: define DAC_FRAME_RX_STRICT_CMD_EN to check the command
// nibble and zero tail; otherwise only frame length gates acceptance.
module dac_frame_rx
    import dac_rx_pkg::*;
#(
    parameter int         FRAME_WIDTH  = DEF_FRAME_WIDTH,
    parameter int         CODE_WIDTH   = DEF_CODE_WIDTH,
    parameter int         SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter logic [3:0] EXPECTED_CMD = DEF_EXPECTED_CMD
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    input  logic [31:0]           wb_adr_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic [3:0]            wb_sel_i,
    output logic                  wb_ack_o,
    input  logic                  sync_i,
    input  logic                  sclk_i,
    input  logic                  sdi_i,
    output logic [CODE_WIDTH-1:0] code_o,
    output logic                  code_vld_o,
    output logic                  frame_err_o
);

    logic sync_s, sync_rise, sync_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic sdi_s, sdi_rise, sdi_fall;

    // sdi shares the synchronizer depth so it stays aligned with sclk edges
    sig_sync #(.STAGES(SYNC_STAGES)) u_sync_sync (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .din(sync_i),
        .q(sync_s), .rise(sync_rise), .fall(sync_fall));
    sig_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .din(sclk_i),
        .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
    sig_sync #(.STAGES(SYNC_STAGES)) u_sdi_sync (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .din(sdi_i),
        .q(sdi_s), .rise(sdi_rise), .fall(sdi_fall));

    rx_state_e              state;
    logic [FRAME_WIDTH-1:0] shreg;
    logic [FRAME_WIDTH-1:0] raw_reg;
    logic [4:0]             bit_cnt;
    logic                   len_bad, cmd_bad, frame_ok, frame_bad;

    assign len_bad = (bit_cnt != 5'(FRAME_WIDTH));
`ifdef DAC_FRAME_RX_STRICT_CMD_EN
    assign cmd_bad = (shreg[FRAME_WIDTH-1 -: 4] != EXPECTED_CMD) || (shreg[3:0] != 4'd0);
`else
    assign cmd_bad = 1'b0;
`endif
    assign frame_ok  = (state == ST_CHECK) && !len_bad && !cmd_bad;
    assign frame_bad = (state == ST_CHECK) && (len_bad || cmd_bad);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= ST_ARM;
            shreg       <= '0;
            bit_cnt     <= '0;
            raw_reg     <= '0;
            code_o      <= '0;
            code_vld_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            code_vld_o  <= 1'b0;
            frame_err_o <= 1'b0;
            case (state)
                // a sync still low after reset belongs to a discarded frame
                ST_ARM: if (sync_s) state <= ST_IDLE;
                ST_IDLE: begin
                    if (sync_fall) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // an sclk fall in the same cycle as sync rise still counts
                    if (sclk_fall) begin
                        shreg <= {shreg[FRAME_WIDTH-2:0], sdi_s};
                        if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
                    end
                    if (sync_rise) state <= ST_CHECK;
                end
                ST_CHECK: begin
                    raw_reg <= shreg;
                    if (frame_ok) begin
                        code_o     <= shreg[CODE_WIDTH+3:4];
                        code_vld_o <= 1'b1;
                    end
                    frame_err_o <= frame_bad;
                    state       <= ST_IDLE;
                end
                default: state <= ST_ARM;
            endcase
        end
    end

    // Wishbone slave and status registers
    logic        frame_vld, len_err, cmd_err;
    logic [15:0] frame_cnt;
    logic        wb_req, wr_stat;
    logic [31:0] rd_data;

    // ack-gated so a held strobe still yields single-cycle acks
    assign wb_req  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr_stat = wb_req & wb_we_i & wb_sel_i[0] & (wb_adr_i[3:2] == STATUS_REG);

    always_comb begin
        rd_data = '0;
        case (wb_adr_i[3:2])
            STATUS_REG: begin
                rd_data[STAT_VLD_BIT]       = frame_vld;
                rd_data[STAT_LEN_BIT]       = len_err;
                rd_data[STAT_CMD_BIT]       = cmd_err;
                rd_data[STAT_CNT_LSB +: 16] = frame_cnt;
            end
            CODE_REG: rd_data[CODE_WIDTH-1:0]  = code_o;
            RAW_REG:  rd_data[FRAME_WIDTH-1:0] = raw_reg;
            default:  rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            frame_vld <= 1'b0;
            len_err   <= 1'b0;
            cmd_err   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            wb_ack_o <= wb_req;
            if (wb_req && !wb_we_i) wb_dat_o <= rd_data;

            // W1C first, then sets, so a same-cycle set wins
            if (wr_stat) begin
                if (wb_dat_i[STAT_VLD_BIT]) frame_vld <= 1'b0;
                if (wb_dat_i[STAT_LEN_BIT]) len_err   <= 1'b0;
                if (wb_dat_i[STAT_CMD_BIT]) cmd_err   <= 1'b0;
            end
            if (frame_ok)             frame_vld <= 1'b1;
            if (frame_bad && len_bad) len_err   <= 1'b1;
            if (frame_bad && cmd_bad) cmd_err   <= 1'b1;

            if (wr_stat && wb_dat_i[STAT_CLR_CNT_BIT])
                frame_cnt <= frame_ok ? 16'd1 : 16'd0;
            else if (frame_ok)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:4], wb_sel_i[3:1],
                         sclk_s, sclk_rise, sdi_rise, sdi_fall, EXPECTED_CMD};

endmodule

// File: tb/tb_dac_frame_rx.sv
// tb_dac_frame_rx: scoreboard bench for dac_frame_rx. Frames are driven
// bit-serially; each frame pushes its expected event (code or error) to a
// queue that a negedge monitor pops when code_vld_o / frame_err_o pulse.
// Register contents are checked against a small reference model.
module tb_dac_frame_rx;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_adr_i = '0;
    logic        wb_we_i  = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [3:0]  wb_sel_i = 4'h0;
    logic        wb_ack_o;
    logic        sync_i = 1'b1;
    logic        sclk_i = 1'b1;
    logic        sdi_i  = 1'b0;
    logic [15:0] code_o;
    logic        code_vld_o;
    logic        frame_err_o;

    dac_frame_rx dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_adr_i(wb_adr_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o),
        .sync_i(sync_i), .sclk_i(sclk_i), .sdi_i(sdi_i),
        .code_o(code_o), .code_vld_o(code_vld_o), .frame_err_o(frame_err_o));

    always #5 wb_clk_i = ~wb_clk_i;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // reference model
    typedef struct { bit err; logic [15:0] code; } ev_t;
    ev_t         sbq[$];
    logic [15:0] exp_code = '0;
    logic [15:0] exp_cnt  = '0;
    logic [23:0] exp_raw  = '0;
    bit          exp_vld = 0, exp_len = 0, exp_cmd = 0;

    function automatic logic [31:0] exp_status();
        return {exp_cnt, 13'd0, exp_cmd, exp_len, exp_vld};
    endfunction

    function automatic void model_reset();
        exp_code = '0; exp_cnt = '0; exp_raw = '0;
        exp_vld = 0; exp_len = 0; exp_cmd = 0;
    endfunction

    function automatic void expect_frame(input logic [31:0] data, input int nbits);
        logic [31:0] r;
        bit len_ok, cmd_ok;
        ev_t ev;
        r = (nbits >= 24) ? data : (data & ((32'h1 << nbits) - 32'h1));
        len_ok = (nbits == 24);
`ifdef DAC_FRAME_RX_STRICT_CMD_EN
        cmd_ok = (r[23:20] == 4'h3) && (r[3:0] == 4'h0);
`else
        cmd_ok = 1;
`endif
        exp_raw = r[23:0];
        if (len_ok && cmd_ok) begin
            exp_code = r[19:4];
            exp_vld  = 1;
            exp_cnt  = exp_cnt + 16'd1;
            ev.err   = 0;
        end else begin
            if (!len_ok) exp_len = 1;
            if (!cmd_ok) exp_cmd = 1;
            ev.err = 1;
        end
        ev.code = exp_code;
        sbq.push_back(ev);
    endfunction

    // event monitor
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i && (code_vld_o || frame_err_o)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_evt", {30'd0, frame_err_o, code_vld_o}, 32'd0);
            end else begin
                ev_t ev;
                ev = sbq.pop_front();
                chk("evt_kind", {30'd0, frame_err_o, code_vld_o}, ev.err ? 32'd2 : 32'd1);
                chk("evt_code", {16'd0, code_o}, {16'd0, ev.code});
            end
        end
    end

    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat, output int lat);
        @(negedge wb_clk_i);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wdat; wb_sel_i = sel;
        lat = 0;
        do begin
            @(negedge wb_clk_i);
            lat++;
        end while (!wb_ack_o && lat < 8);
        chk("wb_ack", {31'd0, wb_ack_o}, 32'd1);
        rdat = wb_dat_o;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        int lat;
        wb_xfer(adr, 1'b0, 32'd0, 4'hF, d, lat);
        chk(tag, d, exp);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] dummy;
        int lat;
        wb_xfer(adr, 1'b1, d, sel, dummy, lat);
    endtask

    // rst_at >= 0: pulse reset after that many bits; coin: raise sync with
    // the last sclk fall; clr: STATUS count-clear lands on the CHECK edge
    task automatic send_frame(input logic [31:0] data, input int nbits, input int half,
                              input int rst_at, input bit coin, input bit clr);
        @(negedge wb_clk_i);
        sync_i = 0; sclk_i = 1;
        repeat (half) @(negedge wb_clk_i);
        for (int i = nbits - 1; i >= 0; i--) begin
            sdi_i = data[i];
            if (rst_at == nbits - 1 - i) begin
                wb_rst_i = 1;
                repeat (3) @(negedge wb_clk_i);
                wb_rst_i = 0;
                model_reset();
            end
            repeat (half) @(negedge wb_clk_i);
            sclk_i = 0;
            if (coin && i == 0) begin
                sync_i = 1;
                if (rst_at < 0) expect_frame(data, nbits);
            end
            repeat (half) @(negedge wb_clk_i);
            sclk_i = 1;
        end
        if (!coin) begin
            repeat (half) @(negedge wb_clk_i);
            sync_i = 1;
            if (rst_at < 0) expect_frame(data, nbits);
            if (clr) begin
                // sync edge + SYNC_STAGES + 1 puts the FSM in CHECK on the next edge
                repeat (3) @(negedge wb_clk_i);
                wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 32'h0;
                wb_dat_i = 32'h8; wb_sel_i = 4'hF;
                @(negedge wb_clk_i);
                chk("clr_ack", {31'd0, wb_ack_o}, 32'd1);
                wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
                exp_cnt = 16'd1;
            end
        end
        repeat (8) @(negedge wb_clk_i);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int lat;

        repeat (3) @(negedge wb_clk_i);
        chk("rst_code",   {16'd0, code_o}, 32'd0);
        chk("rst_vld",    {31'd0, code_vld_o}, 32'd0);
        chk("rst_err",    {31'd0, frame_err_o}, 32'd0);
        chk("rst_ack",    {31'd0, wb_ack_o}, 32'd0);
        chk("rst_dat",    wb_dat_o, 32'd0);
        wb_rst_i = 0;
        repeat (5) @(negedge wb_clk_i);
        rd_chk("rst_status", 32'h0, 32'd0);
        rd_chk("rst_raw",    32'h8, 32'd0);

        send_frame(32'h3ABCD0, 24, 3, -1, 0, 0);
        rd_chk("f1_status", 32'h0, exp_status());
        rd_chk("f1_code",   32'h4, {16'd0, exp_code});
        rd_chk("f1_raw",    32'h8, {8'd0, exp_raw});

        send_frame(32'h212340, 24, 3, -1, 0, 0);
        rd_chk("f2_status", 32'h0, exp_status());
        rd_chk("f2_code",   32'h4, {16'd0, exp_code});
        rd_chk("f2_raw",    32'h8, {8'd0, exp_raw});

        send_frame(32'h1D5E68, 23, 2, -1, 0, 0);
        rd_chk("len23_status", 32'h0, exp_status());
        rd_chk("len23_raw",    32'h8, {8'd0, exp_raw});
        send_frame(32'h13ABCD0, 25, 2, -1, 0, 0);
        rd_chk("len25_status", 32'h0, exp_status());
        rd_chk("len25_raw",    32'h8, {8'd0, exp_raw});

        // last sclk fall coincides with sync rise
        send_frame(32'h3C0DE0, 24, 3, -1, 1, 0);
        rd_chk("coin_code",   32'h4, {16'd0, exp_code});
        rd_chk("coin_status", 32'h0, exp_status());

        // count clear on the same edge as an accepted frame -> 1
        send_frame(32'h355550, 24, 3, -1, 0, 1);
        rd_chk("clr_status", 32'h0, exp_status());

        // W1C on upper byte lanes only is ignored
        wr(32'h0, 32'h7, 4'b1110);
        rd_chk("w1c_nosel", 32'h0, exp_status());
        wr(32'h0, 32'h7, 4'b0001);
        exp_vld = 0; exp_len = 0; exp_cmd = 0;
        rd_chk("w1c_status", 32'h0, exp_status());
        wr(32'h4, 32'hFFFF, 4'hF);
        rd_chk("code_ro", 32'h4, {16'd0, exp_code});

        // reset after 10 bits, released with sync low: frame dropped
        send_frame(32'h3FFFF0, 24, 3, 10, 0, 0);
        rd_chk("rst_mid_status", 32'h0, 32'd0);
        rd_chk("rst_mid_code",   32'h4, 32'd0);
        rd_chk("rst_mid_raw",    32'h8, 32'd0);
        send_frame(32'h300010, 24, 3, -1, 0, 0);
        rd_chk("after_rst_code",   32'h4, 32'h0001);
        rd_chk("after_rst_status", 32'h0, exp_status());

        // counter wrap, preloaded near the top
        @(negedge wb_clk_i);
        force dut.frame_cnt = 16'hFFFE;
        @(negedge wb_clk_i);
        release dut.frame_cnt;
        exp_cnt = 16'hFFFE;
        send_frame(32'h312340, 24, 2, -1, 0, 0);
        rd_chk("cnt_ffff", 32'h0, exp_status());
        send_frame(32'h356780, 24, 2, -1, 0, 0);
        rd_chk("cnt_wrap", 32'h0, exp_status());

        // unmapped address
        wb_xfer(32'hC, 1'b0, 32'd0, 4'hF, d, lat);
        chk("unmapped_dat", d, 32'd0);
        chk("unmapped_lat", lat, 32'd1);
        wr(32'hC, 32'hFFFF_FFFF, 4'hF);
        rd_chk("unmapped_wr_status", 32'h0, exp_status());

        repeat (10) @(negedge wb_clk_i);
        chk("sbq_empty", sbq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
